// File: rtl/conv1d_engine_pkg.sv
// Shared types and constants for the 1-D convolution CFU engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv1d_engine_pkg;

    localparam int DEF_KERNEL_LEN   = 8;
    localparam int DEF_MAX_CHANNELS = 128;
    localparam int DEF_MAX_LEN      = 1024;
    localparam int DEF_ACC_W        = 32;

    // One RAM word carries four int8 channels.
    localparam int CHANNEL_WORDS    = DEF_MAX_CHANNELS / 4;

    // (int8 + int9) -> 10b, x int8 -> 18b, four-lane sum -> 20b.
    localparam int XOFF_W = 10;
    localparam int PROD_W = 18;
    localparam int SUM_W  = 20;

    localparam logic [31:0] CFG_ERR = 32'hFFFF_FFFF;

    typedef enum logic [6:0] {
        CMD_CONFIG       = 7'd0,
        CMD_WRITE_INPUT  = 7'd1,
        CMD_WRITE_WEIGHT = 7'd2,
        CMD_READ_OUTPUT  = 7'd3,
        CMD_START        = 7'd4,
        CMD_SET_BIAS     = 7'd5,
        CMD_SET_OFFSET   = 7'd6,
        CMD_STATUS       = 7'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Number of channel words needed for a channel count.
    function automatic int chan_words(input int channels);
        return channels / 4;
    endfunction

endpackage

// File: rtl/conv1d_mac4.sv
// Four-lane int8 MAC: sum of (x + offset) * w over the lanes of one channel word.
// Latency: 1 cycle (registered 20-bit result).
// Backpressure: none; result register only loads when en is high.
module conv1d_mac4
    import conv1d_engine_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [31:0]             x_word,
    input  logic [31:0]             w_word,
    input  logic signed [8:0]       offset,
    output logic signed [SUM_W-1:0] sum_q
);

    logic signed [SUM_W-1:0]  sum_d;
    logic signed [XOFF_W-1:0] x_off [4];
    logic signed [PROD_W-1:0] prod  [4];

    // Per-lane (x + offset) * w, widened exactly and summed across lanes.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 4; i++) begin
            x_off[i] = $signed({{2{x_word[8*i+7]}}, x_word[8*i +: 8]})
                     + $signed({offset[8], offset});
            prod[i]  = $signed({{(PROD_W-XOFF_W){x_off[i][XOFF_W-1]}}, x_off[i]})
                     * $signed({{(PROD_W-8){w_word[8*i+7]}}, w_word[8*i +: 8]});
            sum_d    = sum_d + $signed({{(SUM_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]});
        end
    end

    // Result register, loaded only for issued terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/conv1d_engine.sv
// Same-padded int8 1-D convolution CFU; build option CONV1D_ENGINE_RELU_EN clamps outputs at zero.
// Latency: 1 cycle for register commands, L*KERNEL_LEN*(C/4)+2 cycles for START.
// Backpressure: cmd_ready low until the pending response is taken with rsp_ready.
module conv1d_engine
    import conv1d_engine_pkg::*;
#(
    parameter int KERNEL_LEN   = DEF_KERNEL_LEN,
    parameter int MAX_CHANNELS = DEF_MAX_CHANNELS,
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int ACC_W        = DEF_ACC_W
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int P        = KERNEL_LEN / 2;
    localparam int CH_WORDS = chan_words(MAX_CHANNELS);
    localparam int IN_DEPTH = MAX_LEN * CH_WORDS;
    localparam int W_DEPTH  = KERNEL_LEN * CH_WORDS;
    localparam int IN_AW    = $clog2(IN_DEPTH);
    localparam int W_AW     = $clog2(W_DEPTH);
    localparam int OW       = $clog2(MAX_LEN);
    localparam int KW       = $clog2(KERNEL_LEN);
    localparam int CW_W     = (CH_WORDS > 1) ? $clog2(CH_WORDS) : 1;

    // Buffers: input rows, kernel taps, output accumulators.
    logic [31:0]      in_ram  [IN_DEPTH];
    logic [31:0]      w_ram   [W_DEPTH];
    logic [ACC_W-1:0] out_ram [MAX_LEN];

    state_e              state_q, state_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_dat_q, rsp_dat_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         ch_q, ch_d;
    logic [ACC_W-1:0]    bias_q, bias_d;
    logic signed [8:0]   off_q, off_d;
    logic [OW-1:0]       o_q, o_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                mac_vld_q, mac_vld_d;
    logic                mac_last_q, mac_last_d;
    logic [OW-1:0]       mac_o_q, mac_o_d;

    cmd_e                cmd;
    logic                accept;
    logic                cfg_ok;
    logic [15:0]         cfg_len, cfg_ch;
    logic                in_we, w_we, wb_we;
    logic [ACC_W-1:0]    wb_dat, final_acc;
    logic                issue;
    logic                cw_last, k_last, o_last;
    logic [16:0]         row_ext, row;
    logic                row_ok;
    logic [IN_AW-1:0]    x_addr;
    logic [W_AW-1:0]     w_addr;
    logic [31:0]         x_word, w_word;
    logic signed [SUM_W-1:0] mac_sum;
    logic                unused_bits;

    assign cmd       = cmd_e'(cmd_payload_function_id[9:3]);
    assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_payload_outputs_0 = rsp_dat_q;
    assign unused_bits = ^cmd_payload_function_id[2:0];

    assign cfg_len = cmd_payload_inputs_0[15:0];
    assign cfg_ch  = cmd_payload_inputs_1[15:0];
    assign cfg_ok  = (cfg_len != 16'd0) && (32'(cfg_len) <= 32'(MAX_LEN))
                  && (cfg_ch[1:0] == 2'b00) && (cfg_ch >= 16'd4)
                  && (32'(cfg_ch) <= 32'(MAX_CHANNELS));

    // Loop counters: channel word innermost, then tap, then output index.
    assign cw_last = (16'(cw_q) == (ch_q >> 2) - 16'd1);
    assign k_last  = (k_q == KW'(KERNEL_LEN - 1));
    assign o_last  = (16'(o_q) == len_q - 16'd1);

    // Input row for the current tap; rows outside 0..L-1 are padding.
    always_comb begin
        row_ext = 17'(o_q) + 17'(k_q);
        row     = row_ext - 17'(P);
        row_ok  = (row_ext >= 17'(P)) && (row < {1'b0, len_q});
        x_addr  = row_ok ? IN_AW'(32'(row) * CH_WORDS + 32'(cw_q)) : '0;
        w_addr  = W_AW'(32'(k_q) * CH_WORDS + 32'(cw_q));
    end

    // Padding terms get a zero weight word so their product vanishes.
    assign x_word = in_ram[x_addr];
    assign w_word = row_ok ? w_ram[w_addr] : 32'd0;

    conv1d_mac4 u_mac4 (
        .clk    (clk),
        .rst_n  (reset_n),
        .en     (issue),
        .x_word (x_word),
        .w_word (w_word),
        .offset (off_q),
        .sum_q  (mac_sum)
    );

    // Next-state: command decode, run loop, accumulate and writeback.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        len_d       = len_q;
        ch_d        = ch_q;
        bias_d      = bias_q;
        off_d       = off_q;
        o_d         = o_q;
        k_d         = k_q;
        cw_d        = cw_q;
        acc_d       = acc_q;
        in_we       = 1'b0;
        w_we        = 1'b0;
        issue       = 1'b0;
        wb_we       = 1'b0;
        wb_dat      = '0;
        final_acc   = acc_q + {{(ACC_W-SUM_W){mac_sum[SUM_W-1]}}, mac_sum};

        // Writeback stage: fold each MAC result in, store on an output's last term.
        if (mac_vld_q) begin
            if (mac_last_q) begin
                wb_we = 1'b1;
`ifdef CONV1D_ENGINE_RELU_EN
                wb_dat = final_acc[ACC_W-1] ? '0 : final_acc;
`else
                wb_dat = final_acc;
`endif
                acc_d = bias_q;
            end else begin
                acc_d = final_acc;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'd0;
                    case (cmd)
                        CMD_CONFIG: begin
                            if (cfg_ok) begin
                                len_d = cfg_len;
                                ch_d  = cfg_ch;
                            end else begin
                                rsp_dat_d = CFG_ERR;
                            end
                        end
                        CMD_WRITE_INPUT:  in_we = (cmd_payload_inputs_0 < 32'(IN_DEPTH));
                        CMD_WRITE_WEIGHT: w_we  = (cmd_payload_inputs_0 < 32'(W_DEPTH));
                        CMD_READ_OUTPUT: begin
                            if (cmd_payload_inputs_0 < 32'(MAX_LEN)) begin
                                rsp_dat_d = 32'(out_ram[cmd_payload_inputs_0[OW-1:0]]);
                            end
                        end
                        CMD_START: begin
                            state_d     = ST_RUN;
                            rsp_valid_d = 1'b0;
                            rsp_dat_d   = {16'd0, len_q};
                            o_d         = '0;
                            k_d         = '0;
                            cw_d        = '0;
                            acc_d       = bias_q;
                        end
                        CMD_SET_BIAS:   bias_d    = ACC_W'(cmd_payload_inputs_0);
                        CMD_SET_OFFSET: off_d     = cmd_payload_inputs_0[8:0];
                        CMD_STATUS:     rsp_dat_d = {ch_q, len_q};
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (cw_last) begin
                    cw_d = '0;
                    if (k_last) begin
                        k_d = '0;
                        if (o_last) begin
                            state_d = ST_DRAIN;
                        end else begin
                            o_d = o_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    cw_d = cw_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mac_vld_d  = issue;
        mac_last_d = issue && cw_last && k_last;
        mac_o_d    = o_q;
    end

    // Control, configuration and pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            len_q       <= 16'(MAX_LEN);
            ch_q        <= 16'(MAX_CHANNELS);
            bias_q      <= '0;
            off_q       <= '0;
            o_q         <= '0;
            k_q         <= '0;
            cw_q        <= '0;
            acc_q       <= '0;
            mac_vld_q   <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_o_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            len_q       <= len_d;
            ch_q        <= ch_d;
            bias_q      <= bias_d;
            off_q       <= off_d;
            o_q         <= o_d;
            k_q         <= k_d;
            cw_q        <= cw_d;
            acc_q       <= acc_d;
            mac_vld_q   <= mac_vld_d;
            mac_last_q  <= mac_last_d;
            mac_o_q     <= mac_o_d;
        end
    end

    // Buffer writes; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (in_we) begin
            in_ram[cmd_payload_inputs_0[IN_AW-1:0]] <= cmd_payload_inputs_1;
        end
        if (w_we) begin
            w_ram[cmd_payload_inputs_0[W_AW-1:0]] <= cmd_payload_inputs_1;
        end
        if (wb_we) begin
            out_ram[mac_o_q] <= wb_dat;
        end
    end

endmodule

// File: tb/tb_conv1d_engine.sv
// Self-checking bench for conv1d_engine: directed command sequences against a behavioural model.
// A negedge monitor checks every response cycle; tasks check latency, handshake and literal values.
// Bounded waits everywhere; a global watchdog ends the run if the bench itself stalls.
`timescale 1ns/1ps
module tb_conv1d_engine;

    localparam int K    = 8;
    localparam int P    = K / 2;
    localparam int MAXC = 128;
    localparam int MAXL = 1024;
    localparam int CW   = MAXC / 4;

    localparam logic [6:0] F_CONFIG = 7'd0;
    localparam logic [6:0] F_WIN    = 7'd1;
    localparam logic [6:0] F_WW     = 7'd2;
    localparam logic [6:0] F_READ   = 7'd3;
    localparam logic [6:0] F_START  = 7'd4;
    localparam logic [6:0] F_BIAS   = 7'd5;
    localparam logic [6:0] F_OFF    = 7'd6;
    localparam logic [6:0] F_STATUS = 7'd7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  fid = '0;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;

    always #5 clk = ~clk;

    conv1d_engine dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_dat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    logic [31:0] m_in  [MAXL*CW];
    logic [31:0] m_w   [K*CW];
    int          m_out [MAXL];
    int          m_len, m_ch, m_bias, m_off;
    logic [31:0] exp_rsp = '0;
    bit          exp_active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int sbyte(input logic [31:0] w, input int lane);
        logic signed [7:0] b;
        b = w[8*lane +: 8];
        return int'(b);
    endfunction

    function automatic logic [31:0] pack4(input int b0, input int b1, input int b2, input int b3);
        return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    task automatic model_reset();
        m_len = MAXL; m_ch = MAXC; m_bias = 0; m_off = 0;
    endtask

    // Straight from the definition: bias + sum over taps and channels, padding rows skipped.
    task automatic model_conv();
        for (int o = 0; o < m_len; o++) begin
            int acc;
            acc = m_bias;
            for (int k = 0; k < K; k++) begin
                int r;
                r = o + k - P;
                if (r >= 0 && r < m_len) begin
                    for (int c = 0; c < m_ch; c++) begin
                        acc += (sbyte(m_in[r*CW + c/4], c%4) + m_off) * sbyte(m_w[k*CW + c/4], c%4);
                    end
                end
            end
`ifdef CONV1D_ENGINE_RELU_EN
            if (acc < 0) acc = 0;
`endif
            m_out[o] = acc;
        end
    endtask

    task automatic model_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r);
        logic signed [8:0] o9;
        r = 32'd0;
        case (f)
            F_CONFIG: begin
                if (a[15:0] >= 1 && a[15:0] <= MAXL && b[1:0] == 2'b00 &&
                    b[15:0] >= 4 && b[15:0] <= MAXC) begin
                    m_len = int'(a[15:0]);
                    m_ch  = int'(b[15:0]);
                end else begin
                    r = 32'hFFFF_FFFF;
                end
            end
            F_WIN:    if (a < MAXL*CW) m_in[a] = b;
            F_WW:     if (a < K*CW) m_w[a] = b;
            F_READ:   r = (a < MAXL) ? m_out[a] : 32'd0;
            F_START: begin
                model_conv();
                r = m_len;
            end
            F_BIAS:   m_bias = a;
            F_OFF: begin
                o9 = a[8:0];
                m_off = int'(o9);
            end
            F_STATUS: r = {m_ch[15:0], m_len[15:0]};
            default: ;
        endcase
    endtask

    // Issue one command, check latency, optionally hold rsp_ready low for `hold` cycles.
    task automatic send(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] r);
        logic [31:0] e;
        int explat, lat, n;
        explat = (f == F_START) ? m_len * K * (m_ch / 4) + 2 : 1;
        model_cmd(f, a, b, e);
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        exp_rsp = e;
        exp_active = 1'b1;
        cmd_valid = 1'b1; fid = {f, 3'b000}; in0 = a; in1 = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(explat));
        r = rsp_dat;
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                cmd_valid = 1'b1; fid = {F_CONFIG, 3'b000}; in0 = 32'd2; in1 = 32'd4;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        exp_active = 1'b0;
    endtask

    // Response monitor: payload must match the model, no command may be taken, none unexpected.
    always @(negedge clk) begin
        if (rsp_valid) begin
            chk("rsp_expected", 32'(exp_active), 32'd1);
            chk("rsp_payload", rsp_dat, exp_rsp);
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_payload", rsp_dat, 32'd0);
        reset_n = 1'b1;

        send(F_STATUS, 0, 0, 0, r);        chk("status_reset", r, 32'h0080_0400);
        send(F_CONFIG, 0, 4, 0, r);        chk("cfg_len0", r, 32'hFFFF_FFFF);
        send(F_CONFIG, 8, 6, 0, r);        chk("cfg_c6", r, 32'hFFFF_FFFF);
        send(F_CONFIG, 1025, 4, 0, r);     chk("cfg_len1025", r, 32'hFFFF_FFFF);
        send(F_CONFIG, 8, 132, 0, r);      chk("cfg_c132", r, 32'hFFFF_FFFF);
        send(F_STATUS, 0, 0, 0, r);        chk("status_kept", r, 32'h0080_0400);
        send(7'd9, 1, 2, 0, r);            chk("unknown_cmd", r, 32'd0);

        // Mixed-sign pattern, L=6, C=8.
        send(F_CONFIG, 6, 8, 0, r);
        send(F_OFF, 3, 0, 0, r);
        send(F_BIAS, 1000, 0, 0, r);
        for (int row = 0; row < 6; row++)
            for (int cw = 0; cw < 2; cw++)
                send(F_WIN, row*CW + cw, pack4((row*3 + (4*cw+0)*5) % 17 - 8, (row*3 + (4*cw+1)*5) % 17 - 8,
                                               (row*3 + (4*cw+2)*5) % 17 - 8, (row*3 + (4*cw+3)*5) % 17 - 8), 0, r);
        for (int k = 0; k < K; k++)
            for (int cw = 0; cw < 2; cw++)
                send(F_WW, k*CW + cw, pack4((k*5 + (4*cw+0)*3) % 11 - 5, (k*5 + (4*cw+1)*3) % 11 - 5,
                                            (k*5 + (4*cw+2)*3) % 11 - 5, (k*5 + (4*cw+3)*3) % 11 - 5), 0, r);
        send(F_WIN, MAXL*CW, 32'hDEAD_BEEF, 0, r);
        send(F_START, 0, 0, 0, r);         chk("start6_rsp", r, 32'd6);
        for (int o = 0; o < 6; o++) send(F_READ, o, 0, 0, r);

        // All-ones pattern, L=4, C=4: every output sees four real taps of four lanes.
        send(F_CONFIG, 4, 4, 0, r);
        send(F_OFF, 0, 0, 0, r);
        send(F_BIAS, 0, 0, 0, r);
        for (int k = 0; k < K; k++) send(F_WW, k*CW, 32'h0101_0101, 0, r);
        for (int row = 0; row < 4; row++) send(F_WIN, row*CW, 32'h0101_0101, 0, r);
        send(F_START, 0, 0, 0, r);         chk("start4_rsp", r, 32'd4);
        send(F_READ, 0, 0, 0, r);          chk("ones_out0", r, 32'd16);
        send(F_READ, 3, 0, 0, r);          chk("ones_out3", r, 32'd16);
        send(F_READ, 1, 0, 0, r);
        send(F_READ, 4, 0, 0, r);
        send(F_READ, 5, 0, 0, r);
        send(F_READ, 1024, 0, 0, r);       chk("read_oob", r, 32'd0);

        // Negative bias with offset: -100 + 4 taps * 4 lanes * (1+1)*1.
        send(F_BIAS, 32'hFFFF_FF9C, 0, 0, r);
        send(F_OFF, 1, 0, 0, r);
        send(F_START, 0, 0, 0, r);
        send(F_READ, 0, 0, 0, r);
`ifdef CONV1D_ENGINE_RELU_EN
        chk("bias_off_out0", r, 32'd0);
`else
        chk("bias_off_out0", r, 32'hFFFF_FFBC);
`endif

        // Extremes, L=1, C=4: only tap P hits row 0; 4 * (-256 * -128).
        send(F_CONFIG, 1, 4, 0, r);
        send(F_BIAS, 0, 0, 0, r);
        send(F_OFF, 32'h180, 0, 0, r);
        send(F_WIN, 0, 32'h8080_8080, 0, r);
        for (int k = 0; k < K; k++) send(F_WW, k*CW, 32'h8080_8080, 0, r);
        send(F_START, 0, 0, 0, r);         chk("start1_rsp", r, 32'd1);
        send(F_READ, 0, 0, 0, r);          chk("extreme_out0", r, 32'h0002_0000);
        send(F_READ, 1, 0, 0, r);

        // Response held for 10 cycles; a CONFIG pulse in that window must be ignored.
        send(F_CONFIG, 2000, 4, 10, r);    chk("hold_cfg_rsp", r, 32'hFFFF_FFFF);
        send(F_STATUS, 0, 0, 0, r);        chk("status_after_hold", r, 32'h0004_0001);

        // Reset five cycles into a START: no response, configuration back to defaults.
        send(F_CONFIG, 4, 4, 0, r);
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1; fid = {F_START, 3'b000}; in0 = 0; in1 = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("midrun_rst_valid", 32'(rsp_valid), 32'd0);
        chk("midrun_rst_ready", 32'(cmd_ready), 32'd1);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrun_no_rsp", 32'(rsp_valid), 32'd0);
        send(F_STATUS, 0, 0, 0, r);        chk("status_after_rst", r, 32'h0080_0400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
